// File: rtl/tick_speed_ctrl.sv
// rtl/tick_speed_ctrl.sv - tick enable generator with debounced four-speed push button
module tick_speed_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clki,
    input  logic       rs,
    input  logic       btn,
    input  logic       run,
    output logic       tick,
    output logic [1:0] speed
);

    localparam int DIV0  = CLK_HZ;
    localparam int DIV1  = CLK_HZ / 2;
    localparam int DIV2  = CLK_HZ / 4;
    localparam int DIV3  = CLK_HZ / 8;
    localparam int CNT_W = $clog2(CLK_HZ);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    // Terminal counts: a tick period of DIVn cycles ends when the counter reads DIVn-1.
    localparam logic [CNT_W-1:0] TERM0 = CNT_W'(DIV0 - 1);
    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(DIV3 - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             deb_level;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_done;
    logic             press;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;

    // The mismatch count is about to reach DEB_CYCLES: accept s2 as the new level this edge.
    assign deb_done = (s2 != deb_level) && (deb_cnt == DEB_LAST);
    // Only an accepted 0->1 change is a press; releases never touch the speed.
    assign press    = deb_done && s2;

    // Select the terminal count for the current speed.
    always_comb begin
        term = TERM0;
        case (speed)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            2'd3:    term = TERM3;
            default: term = TERM0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debouncer: any sample matching the current level restarts the stability count.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (s2 == deb_level) begin
            deb_cnt   <= '0;
        end else if (deb_done) begin
            deb_level <= s2;
            deb_cnt   <= '0;
        end else begin
            deb_cnt   <= deb_cnt + 1'b1;
        end
    end

    // Speed index steps 0,1,2,3,0 on each accepted press.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            speed <= 2'd0;
        end else if (press) begin
            speed <= speed + 2'd1;
        end
    end

    // Tick counter: a speed change restarts the period and suppresses a coincident tick.
    always_ff @(posedge clki or negedge rs) begin
        if (!rs) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (press) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == term) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_speed_ctrl.sv
// tb/tb_tick_speed_ctrl.sv - self-checking bench for tick_speed_ctrl
module tb_tick_speed_ctrl;

    localparam int CLK_HZ = 16;
    localparam int DEB    = 4;

    logic       clki = 1'b0;
    logic       rs   = 1'b1;
    logic       btn  = 1'b0;
    logic       run  = 1'b0;
    logic       tick;
    logic [1:0] speed;

    tick_speed_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
        .clki  (clki),
        .rs    (rs),
        .btn   (btn),
        .run   (run),
        .tick  (tick),
        .speed (speed)
    );

    always #5 clki = ~clki;

    int tests = 0;
    int fails = 0;

    // Reference model state: speed, debounced level, run-cycles since the last
    // period restart, and the raw button history seen since reset.
    int   m_speed;
    int   m_level;
    int   m_runs;
    bit   m_tick;
    bit   hist[$];
    bit   s2q[$];
    int   edge_n;
    int   last_tick;
    bit   clean;
    logic prev_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_speed   = 0;
        m_level   = 0;
        m_runs    = 0;
        m_tick    = 0;
        hist.delete();
        s2q.delete();
        edge_n    = 0;
        last_tick = -1;
        clean     = 0;
        prev_tick = 1'b0;
    endtask

    // Level changes once the last DEB synchronized samples all disagree with it;
    // a tick falls on every run-cycle count that is a multiple of the divider.
    task automatic model_edge(input bit b, input bit r);
        bit d;
        bit s2v;
        bit all_diff;
        int div;
        hist.push_back(b);
        if (hist.size() > 3) d = hist.pop_front();
        s2v = (hist.size() == 3) ? hist[0] : 1'b0;
        s2q.push_back(s2v);
        if (s2q.size() > DEB) d = s2q.pop_front();
        all_diff = (s2q.size() == DEB);
        foreach (s2q[i]) if (int'(s2q[i]) == m_level) all_diff = 0;
        div = CLK_HZ >> m_speed;
        if (all_diff && m_level == 0) begin
            m_level = 1;
            m_speed = (m_speed + 1) % 4;
            m_runs  = 0;
            m_tick  = 0;
            clean   = 0;
        end else begin
            if (all_diff) m_level = 0;
            if (r) begin
                m_runs++;
                m_tick = (m_runs % div == 0);
            end else begin
                m_tick = 0;
                clean  = 0;
            end
        end
    endtask

    task automatic step(input bit b, input bit r);
        btn = b;
        run = r;
        @(posedge clki);
        edge_n++;
        model_edge(b, r);
        #1;
        chk("tick", tick, m_tick);
        chk("speed", speed, m_speed);
        chk("tick_double", tick & prev_tick, 0);
        if (tick === 1'b1) begin
            if (clean && last_tick >= 0) chk("spacing", edge_n - last_tick, CLK_HZ >> m_speed);
            last_tick = edge_n;
            clean     = 1;
        end
        prev_tick = tick;
    endtask

    task automatic do_reset();
        rs  = 1'b0;
        btn = 1'b0;
        #1;
        chk("rst_tick", tick, 0);
        chk("rst_speed", speed, 0);
        repeat (2) @(posedge clki);
        #1;
        rs = 1'b1;
        model_reset();
    endtask

    initial begin
        int first;
        int second;
        int chg;
        int hold;
        int gap;
        int sp0;
        bit b;
        bit pat[8];
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        #2;
        run = 1'b1;
        do_reset();

        // 1: free-running ticks at speed 0
        first  = -1;
        second = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 1);
            if (tick === 1'b1) begin
                if (first < 0) first = edge_n;
                else if (second < 0) second = edge_n;
            end
        end
        chk("t1_first_tick", first, 16);
        chk("t1_second_tick", second, 32);

        // 2: clean press held 20 cycles
        chg = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 1);
            if (chg < 0 && speed === 2'd1) chg = i + 1;
        end
        chk("t2_change_edge", chg, 6);
        for (int i = 0; i < 30; i++) step(0, 1);
        chk("t2_single_inc", speed, 1);

        // 3: bouncing press
        chg = -1;
        for (int i = 0; i < 12; i++) begin
            step((i < 8) ? pat[i] : 1'b1, 1);
            if (chg < 0 && speed === 2'd2) chg = i + 1;
        end
        chk("t3_change_edge", chg, 10);
        for (int i = 0; i < 20; i++) step(0, 1);
        chk("t3_single_inc", speed, 2);

        // 4: four presses from speed 0, then one landing on a terminal count
        do_reset();
        for (int p = 0; p < 4; p++) begin
            hold = $urandom_range(8, 16);
            gap  = $urandom_range(20, 40);
            for (int i = 0; i < hold; i++) step(1, 1);
            for (int i = 0; i < gap; i++) step(0, 1);
            chk("t4_speed_seq", speed, (p + 1) % 4);
        end
        for (int i = 0; i < 20 && ((m_runs + 6) % (CLK_HZ >> m_speed)) != 0; i++) step(0, 1);
        sp0 = m_speed;
        for (int i = 0; i < 6; i++) step(1, 1);
        chk("t4_tc_speed", speed, (sp0 + 1) % 4);
        chk("t4_tc_no_tick", tick, 0);
        for (int i = 0; i < 30; i++) step(0, 1);

        // random button and run activity against the model
        b = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) b = ~b;
            step(b, ($urandom_range(0, 9) != 0));
        end

        // 5: pause at counter 5 for 10 cycles
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1);
        for (int i = 0; i < 10; i++) step(0, 0);
        first = -1;
        for (int i = 0; i < 40 && first < 0; i++) begin
            step(0, 1);
            if (tick === 1'b1) first = edge_n;
        end
        chk("t5_resume_tick", first, 26);

        // 6: reset mid-period at speed 2 with a press mid-debounce
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) step(1, 1);
            for (int i = 0; i < 10; i++) step(0, 1);
        end
        chk("t6_speed_before", speed, 2);
        for (int i = 0; i < 4; i++) step(1, 1);
        do_reset();
        first = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 1);
            if (first < 0 && tick === 1'b1) first = edge_n;
        end
        chk("t6_first_tick", first, 16);
        chk("t6_speed_after", speed, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
